ctrl_sequencer: RTL and testbench
=================================

// Module: ctrl_sequencer
// PURPOSE
//   Microcode control sequencer for the 8-bit bus CPU: the initiator side of the register
//   load/enable strobes. It steps through T-states, decodes the IR opcode plus ALU flags,
//   and drives one 16-bit control word that every register's load and enable inputs consume.
//   Sits between the instruction/flags registers and all bus-attached registers.
// PARAMETERS
//   NUM_STEPS  5  T-states per instruction before a forced wrap to T0 (legal 5..8).
//   EARLY_END  1  1: a step (>=T2) whose control word is 0 ends the instruction; 0: always run NUM_STEPS.
// PORTS
//   i_clk           in   1   system clock, all state changes on rising edge
//   i_rst           in   1   synchronous reset, active-high
//   i_opcode        in   4   IR[7:4], valid from T2 onward
//   i_carry         in   1   registered carry flag
//   i_zero          in   1   registered zero flag
//   o_ctrl          out  16  control word: 15 HLT,14 MI,13 RI,12 RO,11 IO,10 II,9 AI,8 AO,
//                            7 EO,6 SU,5 BI,4 OI,3 CE,2 CO,1 J,0 FI
//   o_step          out  3   current T-state
//   o_instr_done    out  1   high in the last step of the current instruction
//   o_halted        out  1   CPU halted
// BEHAVIOUR
// - Clock/reset: one clock, i_clk; reset is synchronous and active-high on i_rst.
// - Reset: on a rising edge with i_rst=1: o_step=0, o_halted=0. While i_rst=1, o_ctrl=0 and
//   o_instr_done=0 (combinational gate). Reset mid-instruction abandons it; first post-reset cycle is T0.
// - o_ctrl is combinational from o_step, i_opcode, i_carry, i_zero, o_halted. Registers sample it
//   on the next rising edge, so each control word is active for exactly one cycle.
// - Fetch, all opcodes: T0 = CO|MI (0x4004); T1 = RO|II|CE (0x1408).
// - Execute, T2/T3/T4 (any step not listed = 0x0000):
//     0001 LDA : 0x4800 IO|MI, 0x1200 RO|AI
//     0010 ADD : 0x4800, 0x1020 RO|BI, 0x0281 EO|AI|FI
//     0011 SUB : 0x4800, 0x1020, 0x02C1 EO|AI|SU|FI
//     0100 STA : 0x4800, 0x2100 AO|RI
//     0101 LDI : 0x0A00 IO|AI
//     0110 JMP : 0x0802 IO|J
//     0111 JC  : 0x0802 if i_carry else 0x0000
//     1000 JZ  : 0x0802 if i_zero  else 0x0000
//     1110 OUT : 0x0110 AO|OI
//     1111 HLT : 0x8000 HLT
//     0000 NOP and 1001-1101 : all zero
// - Step counter (3-bit, increments on each rising edge unless halted):
//   * next = 0 if o_step == NUM_STEPS-1;
//   * next = 0 if EARLY_END=1, o_step>=2 and o_ctrl==0;
//   * otherwise next = o_step+1.
//   Steps >= 5 emit 0x0000.
// - o_instr_done = 1 exactly when the next step is 0 (and not halted, not in reset).
// - Halt: a rising edge with o_ctrl[15]=1 sets o_halted. While halted:
//   * o_step freezes at its current value and o_ctrl=0x8000;
//   * o_instr_done=0.
//   Only i_rst clears o_halted.
// - Instruction lengths with EARLY_END=1: NOP/LDI/JMP/OUT/untaken J* = 3 or 4 cycles
//   (the zero step counts); LDA/STA = 5; ADD/SUB = 5 (wrap at NUM_STEPS).
// - Flags are sampled only combinationally during T2; no internal flag storage.
// TESTING
// 1. i_rst=1 for 2 cycles, release, opcode=0000 -> o_ctrl: 0x4004, 0x1408, 0x0000
//    (instr_done=1), then 0x4004; o_step 0,1,2,0.
// 2. opcode=0010 (ADD) -> o_ctrl sequence 0x4004, 0x1408, 0x4800, 0x1020, 0x0281;
//    instr_done only at T4; then o_step=0.
// 3. opcode=0111 with i_carry=1 -> T2 = 0x0802; with i_carry=0 -> T2 = 0x0000 and next o_step=0.
//    Repeat for JZ with i_zero.
// 4. opcode=1111 -> T2 = 0x8000; after the edge o_halted=1, o_step stays 2 for 20 cycles,
//    o_ctrl=0x8000; i_rst=1 for one edge -> o_halted=0, o_step=0.
// 5. Assert i_rst at T3 of an LDA -> o_ctrl=0 during reset; first cycle after release o_ctrl=0x4004.
// 6. EARLY_END=0, opcode=0101 -> five steps 0x4004, 0x1408, 0x0A00, 0x0000, 0x0000,
//    then wrap to T0.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer
// Microcode control sequencer for the 8-bit bus CPU. It walks the T-states of
// each instruction, decodes the IR opcode together with the ALU flags, and
// drives the single 16-bit control word. The load and enable inputs of every
// bus-attached register consume this word.
//
// Parameters
//   NUM_STEPS    T-states per instruction before a forced wrap to T0 (5..8)
//   EARLY_END    1: a step at T2 or later whose control word is zero ends the
//                instruction early; 0: always run all NUM_STEPS steps
//
// Ports
//   i_clk          in   system clock; all state changes on the rising edge
//   i_rst          in   synchronous active-high reset
//   i_opcode[3:0]  in   IR[7:4]; only meaningful from T2 onward
//   i_carry        in   registered carry flag
//   i_zero         in   registered zero flag
//   o_ctrl[15:0]   out  control word (15 HLT,14 MI,13 RI,12 RO,11 IO,10 II,
//                       9 AI,8 AO,7 EO,6 SU,5 BI,4 OI,3 CE,2 CO,1 J,0 FI)
//   o_step[2:0]    out  current T-state
//   o_instr_done   out  high during the last step of the current instruction
//   o_halted       out  CPU halted; only a reset clears it
// ---------------------------------------------------------------------------
module ctrl_sequencer #(
    parameter int NUM_STEPS = 5,
    parameter bit EARLY_END = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_opcode,
    input  logic        i_carry,
    input  logic        i_zero,
    output logic [15:0] o_ctrl,
    output logic [2:0]  o_step,
    output logic        o_instr_done,
    output logic        o_halted
);

    // One-hot control lines. Each microinstruction below is built by OR-ing
    // these together.
    localparam logic [15:0] CTRL_HLT = 16'h8000;
    localparam logic [15:0] CTRL_MI  = 16'h4000;
    localparam logic [15:0] CTRL_RI  = 16'h2000;
    localparam logic [15:0] CTRL_RO  = 16'h1000;
    localparam logic [15:0] CTRL_IO  = 16'h0800;
    localparam logic [15:0] CTRL_II  = 16'h0400;
    localparam logic [15:0] CTRL_AI  = 16'h0200;
    localparam logic [15:0] CTRL_AO  = 16'h0100;
    localparam logic [15:0] CTRL_EO  = 16'h0080;
    localparam logic [15:0] CTRL_SU  = 16'h0040;
    localparam logic [15:0] CTRL_BI  = 16'h0020;
    localparam logic [15:0] CTRL_OI  = 16'h0010;
    localparam logic [15:0] CTRL_CE  = 16'h0008;
    localparam logic [15:0] CTRL_CO  = 16'h0004;
    localparam logic [15:0] CTRL_J   = 16'h0002;
    localparam logic [15:0] CTRL_FI  = 16'h0001;

    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    logic [15:0] micro_word;
    logic [15:0] ctrl_word;
    logic [2:0]  next_step;

    // Microcode ROM. T0/T1 form the common fetch. T2..T4 form the
    // opcode-specific execute phase. Anything outside the table (including
    // steps 5..7 when NUM_STEPS is larger than 5) is an idle zero word.
    // Conditional jumps look at the flags here combinationally. The flags are
    // never latched locally.
    always_comb begin
        micro_word = 16'h0000;
        case (o_step)
            3'd0: micro_word = CTRL_CO | CTRL_MI;
            3'd1: micro_word = CTRL_RO | CTRL_II | CTRL_CE;
            3'd2: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: micro_word = CTRL_IO | CTRL_MI;
                    OP_LDI: micro_word = CTRL_IO | CTRL_AI;
                    OP_JMP: micro_word = CTRL_IO | CTRL_J;
                    OP_JC:  micro_word = i_carry ? (CTRL_IO | CTRL_J) : 16'h0000;
                    OP_JZ:  micro_word = i_zero  ? (CTRL_IO | CTRL_J) : 16'h0000;
                    OP_OUT: micro_word = CTRL_AO | CTRL_OI;
                    OP_HLT: micro_word = CTRL_HLT;
                    default: micro_word = 16'h0000;
                endcase
            end
            3'd3: begin
                case (i_opcode)
                    OP_LDA:         micro_word = CTRL_RO | CTRL_AI;
                    OP_ADD, OP_SUB: micro_word = CTRL_RO | CTRL_BI;
                    OP_STA:         micro_word = CTRL_AO | CTRL_RI;
                    default:        micro_word = 16'h0000;
                endcase
            end
            3'd4: begin
                case (i_opcode)
                    OP_ADD:  micro_word = CTRL_EO | CTRL_AI | CTRL_FI;
                    OP_SUB:  micro_word = CTRL_EO | CTRL_AI | CTRL_SU | CTRL_FI;
                    default: micro_word = 16'h0000;
                endcase
            end
            default: micro_word = 16'h0000;
        endcase
    end

    // While halted, the HLT line is held asserted so that the clock-gating
    // logic downstream stays stopped. Reset forces the whole word quiet, so
    // no register loads while the machine is being reset.
    always_comb begin
        ctrl_word = o_halted ? CTRL_HLT : micro_word;
        o_ctrl    = i_rst ? 16'h0000 : ctrl_word;
    end

    // Step sequencing. Two cases freeze the counter: the cycle that issues HLT
    // and every cycle after it. This leaves o_step on the T-state that halted
    // the machine. An idle word at T2 or later is treated as end of
    // instruction, so short instructions skip their empty tail.
    always_comb begin
        next_step = o_step + 3'd1;
        if (o_halted || ctrl_word[15]) begin
            next_step = o_step;
        end else if (o_step == LAST_STEP) begin
            next_step = 3'd0;
        end else if (EARLY_END && (o_step >= 3'd2) && (ctrl_word == 16'h0000)) begin
            next_step = 3'd0;
        end
        o_instr_done = !i_rst && !o_halted && (next_step == 3'd0);
    end

    // State registers. Reset abandons any instruction in flight, and the first
    // cycle after reset is T0. The halt flag is sticky until the next reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_step   <= 3'd0;
            o_halted <= 1'b0;
        end else begin
            o_step <= next_step;
            if (ctrl_word[15]) begin
                o_halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ctrl_sequencer
// Self-checking bench for ctrl_sequencer. Two instances share all inputs:
// one uses EARLY_END=1 and one uses EARLY_END=0. A behavioural model runs
// beside them. It holds a microprogram table per opcode and advances an
// integer T-state for each instance. Every cycle, a compare process checks
// both instances against the model. Directed sequences with literal
// expected words pin the model's behaviour. Randomized traffic then follows.
// ---------------------------------------------------------------------------
module tb_ctrl_sequencer;

    logic        i_clk;
    logic        i_rst;
    logic [3:0]  i_opcode;
    logic        i_carry;
    logic        i_zero;

    logic [15:0] ee_ctrl, ne_ctrl;
    logic [2:0]  ee_step, ne_step;
    logic        ee_done, ne_done;
    logic        ee_halted, ne_halted;

    int passCount  = 0;
    int checkCount = 0;

    ctrl_sequencer #(.NUM_STEPS(5), .EARLY_END(1'b1)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_opcode     (i_opcode),
        .i_carry      (i_carry),
        .i_zero       (i_zero),
        .o_ctrl       (ee_ctrl),
        .o_step       (ee_step),
        .o_instr_done (ee_done),
        .o_halted     (ee_halted)
    );

    ctrl_sequencer #(.NUM_STEPS(5), .EARLY_END(1'b0)) dut_ne (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_opcode     (i_opcode),
        .i_carry      (i_carry),
        .i_zero       (i_zero),
        .o_ctrl       (ne_ctrl),
        .o_step       (ne_step),
        .o_instr_done (ne_done),
        .o_halted     (ne_halted)
    );

    // 10-unit clock period.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ------------------------------------------------------------------
    // Behavioural model. prog[op][k] is the execute word for T(2+k).
    // Conditional jumps are stored as taken and are squashed by the flag.
    // ------------------------------------------------------------------
    logic [15:0] prog [16][3];
    int          m_step [2];
    bit          m_halt [2];
    bit          m_valid = 1'b0;
    bit          ee_of [2] = '{1'b1, 1'b0};

    initial begin
        for (int o = 0; o < 16; o++)
            for (int k = 0; k < 3; k++)
                prog[o][k] = 16'h0000;
        prog[1]  = '{16'h4800, 16'h1200, 16'h0000};
        prog[2]  = '{16'h4800, 16'h1020, 16'h0281};
        prog[3]  = '{16'h4800, 16'h1020, 16'h02C1};
        prog[4]  = '{16'h4800, 16'h2100, 16'h0000};
        prog[5]  = '{16'h0A00, 16'h0000, 16'h0000};
        prog[6]  = '{16'h0802, 16'h0000, 16'h0000};
        prog[7]  = '{16'h0802, 16'h0000, 16'h0000};
        prog[8]  = '{16'h0802, 16'h0000, 16'h0000};
        prog[14] = '{16'h0110, 16'h0000, 16'h0000};
        prog[15] = '{16'h8000, 16'h0000, 16'h0000};
    end

    function automatic logic [15:0] expWord(int s, bit h, logic [3:0] op, logic c, logic z);
        logic [15:0] w;
        if (h) return 16'h8000;
        if (s == 0) return 16'h4004;
        if (s == 1) return 16'h1408;
        if (s > 4) return 16'h0000;
        w = prog[op][s-2];
        if (op == 4'd7 && !c) w = 16'h0000;
        if (op == 4'd8 && !z) w = 16'h0000;
        return w;
    endfunction

    function automatic int expNext(int s, bit h, logic [15:0] w, bit ee);
        if (h || w[15]) return s;
        if (s == 4) return 0;
        if (ee && s >= 2 && w == 16'h0000) return 0;
        return s + 1;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    endtask

    // The model advances on the same edge as the DUTs.
    always @(posedge i_clk) begin
        if (i_rst) begin
            m_valid = 1'b1;
            for (int d = 0; d < 2; d++) begin
                m_step[d] = 0;
                m_halt[d] = 1'b0;
            end
        end else if (m_valid) begin
            for (int d = 0; d < 2; d++) begin
                logic [15:0] w;
                w = expWord(m_step[d], m_halt[d], i_opcode, i_carry, i_zero);
                m_step[d] = expNext(m_step[d], m_halt[d], w, ee_of[d]);
                if (w[15]) m_halt[d] = 1'b1;
            end
        end
    end

    // Compare both instances against the model in mid-cycle.
    always @(negedge i_clk) begin
        if (m_valid) begin
            for (int d = 0; d < 2; d++) begin
                logic [15:0] w, ectrl;
                logic        edone;
                w     = expWord(m_step[d], m_halt[d], i_opcode, i_carry, i_zero);
                ectrl = i_rst ? 16'h0000 : w;
                edone = !i_rst && !m_halt[d] && (expNext(m_step[d], m_halt[d], w, ee_of[d]) == 0);
                checkOutput(d ? "ne_ctrl" : "ee_ctrl", d ? ne_ctrl : ee_ctrl, ectrl);
                checkOutput(d ? "ne_step" : "ee_step", 16'(d ? ne_step : ee_step), 16'(m_step[d]));
                checkOutput(d ? "ne_done" : "ee_done", 16'(d ? ne_done : ee_done), 16'(edone));
                checkOutput(d ? "ne_halt" : "ee_halt", 16'(d ? ne_halted : ee_halted), 16'(m_halt[d]));
            end
        end
    end

    // Directed per-cycle literal check on one instance. Called just after a
    // rising edge. It checks at the falling edge and then moves on to the next
    // rising edge.
    task automatic expectCycle(input bit sel, input string name, input logic [15:0] ctrl,
                               input logic [2:0] step, input logic done, input logic halted);
        @(negedge i_clk);
        checkOutput({name, "/ctrl"}, sel ? ne_ctrl : ee_ctrl, ctrl);
        checkOutput({name, "/step"}, 16'(sel ? ne_step : ee_step), 16'(step));
        checkOutput({name, "/done"}, 16'(sel ? ne_done : ee_done), 16'(done));
        checkOutput({name, "/halt"}, 16'(sel ? ne_halted : ee_halted), 16'(halted));
        @(posedge i_clk);
        #1;
    endtask

    task automatic doReset();
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic applyStimulus();
        int haltCnt = 0;
        int haltLim = 4;
        for (int n = 0; n < 3000; n++) begin
            if (m_halt[0] || m_halt[1]) haltCnt++;
            i_rst = ($urandom_range(0, 49) == 0) || (haltCnt > haltLim);
            if (i_rst) begin
                haltCnt = 0;
                haltLim = $urandom_range(2, 10);
            end
            if ($urandom_range(0, 3) == 0) i_opcode = 4'($urandom_range(0, 15));
            i_carry = 1'($urandom_range(0, 1));
            i_zero  = 1'($urandom_range(0, 1));
            @(posedge i_clk);
            #1;
        end
    endtask

    initial begin
        i_rst = 1'b1; i_opcode = 4'h0; i_carry = 1'b0; i_zero = 1'b0;

        // Two reset edges. The outputs are quiet while reset is held.
        @(posedge i_clk); #1;
        @(negedge i_clk);
        checkOutput("rst/ctrl", ee_ctrl, 16'h0000);
        checkOutput("rst/done", 16'(ee_done), 16'h0000);
        checkOutput("rst/step", 16'(ee_step), 16'h0000);
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        // NOP: fetch, one idle step, then back to T0.
        expectCycle(0, "nop0", 16'h4004, 3'd0, 1'b0, 1'b0);
        expectCycle(0, "nop1", 16'h1408, 3'd1, 1'b0, 1'b0);
        expectCycle(0, "nop2", 16'h0000, 3'd2, 1'b1, 1'b0);
        expectCycle(0, "nop3", 16'h4004, 3'd0, 1'b0, 1'b0);

        // ADD runs the full five steps.
        doReset(); i_opcode = 4'h2;
        expectCycle(0, "add0", 16'h4004, 3'd0, 1'b0, 1'b0);
        expectCycle(0, "add1", 16'h1408, 3'd1, 1'b0, 1'b0);
        expectCycle(0, "add2", 16'h4800, 3'd2, 1'b0, 1'b0);
        expectCycle(0, "add3", 16'h1020, 3'd3, 1'b0, 1'b0);
        expectCycle(0, "add4", 16'h0281, 3'd4, 1'b1, 1'b0);
        expectCycle(0, "add5", 16'h4004, 3'd0, 1'b0, 1'b0);

        // JC taken and not taken, then JZ the same way.
        doReset(); i_opcode = 4'h7; i_carry = 1'b1;
        expectCycle(0, "jct0", 16'h4004, 3'd0, 1'b0, 1'b0);
        expectCycle(0, "jct1", 16'h1408, 3'd1, 1'b0, 1'b0);
        expectCycle(0, "jct2", 16'h0802, 3'd2, 1'b0, 1'b0);
        expectCycle(0, "jct3", 16'h0000, 3'd3, 1'b1, 1'b0);
        i_carry = 1'b0;
        expectCycle(0, "jcn0", 16'h4004, 3'd0, 1'b0, 1'b0);
        expectCycle(0, "jcn1", 16'h1408, 3'd1, 1'b0, 1'b0);
        expectCycle(0, "jcn2", 16'h0000, 3'd2, 1'b1, 1'b0);
        expectCycle(0, "jcn3", 16'h4004, 3'd0, 1'b0, 1'b0);
        doReset(); i_opcode = 4'h8; i_zero = 1'b1; i_carry = 1'b1;
        expectCycle(0, "jzt0", 16'h4004, 3'd0, 1'b0, 1'b0);
        expectCycle(0, "jzt1", 16'h1408, 3'd1, 1'b0, 1'b0);
        expectCycle(0, "jzt2", 16'h0802, 3'd2, 1'b0, 1'b0);
        expectCycle(0, "jzt3", 16'h0000, 3'd3, 1'b1, 1'b0);
        i_zero = 1'b0;
        expectCycle(0, "jzn0", 16'h4004, 3'd0, 1'b0, 1'b0);
        expectCycle(0, "jzn1", 16'h1408, 3'd1, 1'b0, 1'b0);
        expectCycle(0, "jzn2", 16'h0000, 3'd2, 1'b1, 1'b0);
        expectCycle(0, "jzn3", 16'h4004, 3'd0, 1'b0, 1'b0);

        // HLT freezes at T2 until reset.
        doReset(); i_opcode = 4'hF;
        expectCycle(0, "hlt0", 16'h4004, 3'd0, 1'b0, 1'b0);
        expectCycle(0, "hlt1", 16'h1408, 3'd1, 1'b0, 1'b0);
        expectCycle(0, "hlt2", 16'h8000, 3'd2, 1'b0, 1'b0);
        i_opcode = 4'h0;
        for (int k = 0; k < 20; k++)
            expectCycle(0, "hltw", 16'h8000, 3'd2, 1'b0, 1'b1);
        i_rst = 1'b1;
        expectCycle(0, "hltr", 16'h0000, 3'd2, 1'b0, 1'b1);
        i_rst = 1'b0;
        expectCycle(0, "hltx", 16'h4004, 3'd0, 1'b0, 1'b0);

        // Reset in the middle of an LDA.
        doReset(); i_opcode = 4'h1;
        expectCycle(0, "lda0", 16'h4004, 3'd0, 1'b0, 1'b0);
        expectCycle(0, "lda1", 16'h1408, 3'd1, 1'b0, 1'b0);
        expectCycle(0, "lda2", 16'h4800, 3'd2, 1'b0, 1'b0);
        i_rst = 1'b1;
        expectCycle(0, "lda3", 16'h0000, 3'd3, 1'b0, 1'b0);
        i_rst = 1'b0;
        expectCycle(0, "ldax", 16'h4004, 3'd0, 1'b0, 1'b0);

        // LDI on the instance that never ends early.
        doReset(); i_opcode = 4'h5;
        expectCycle(1, "ldi0", 16'h4004, 3'd0, 1'b0, 1'b0);
        expectCycle(1, "ldi1", 16'h1408, 3'd1, 1'b0, 1'b0);
        expectCycle(1, "ldi2", 16'h0A00, 3'd2, 1'b0, 1'b0);
        expectCycle(1, "ldi3", 16'h0000, 3'd3, 1'b0, 1'b0);
        expectCycle(1, "ldi4", 16'h0000, 3'd4, 1'b1, 1'b0);
        expectCycle(1, "ldi5", 16'h4004, 3'd0, 1'b0, 1'b0);

        // Randomized traffic, checked by the model compare process.
        applyStimulus();

        @(negedge i_clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
